// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle for the shared FIFO write-port arbiter.
// The master side drives requests and FIFO flags; the slave is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full;
    logic                     fifo_almost_full;
    logic                     fifo_we;
    logic [WIDTH-1:0]         fifo_wdata;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;

    modport master (
        output req_valid, req_last, req_data,
        output fifo_full, fifo_almost_full,
        input  req_ready, fifo_we, fifo_wdata,
        input  grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data,
        input  fifo_full, fifo_almost_full,
        output req_ready, fifo_we, fifo_wdata,
        output grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO among NUM_REQ requesters.
// FIFO_ARB_BURST_LOCK_EN: hold grant until req_last or MAX_BEATS beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 8,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);
    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_grant;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_win;
    logic [ID_W-1:0] w_next_ptr;
    logic            w_any;
    logic            w_lock;
    logic            w_start;
    logic            w_xfer;
    logic            w_release;
    int              w_idx;

    // Outputs are gated by rst so nothing is written in the reset cycle.
    assign w_lock  = (r_state == S_LOCK) && !rst;
    assign w_xfer  = w_lock && bus.req_valid[r_grant] && !bus.fifo_full;
    assign w_start = (r_state == S_IDLE) && w_any && !bus.fifo_almost_full;

    assign w_next_ptr = ID_W'((int'(r_grant) + 1) % NUM_REQ);

    // Downward scan so the closest requester at/after r_ptr wins last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (bus.req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = ID_W'(w_idx);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_lock && !bus.fifo_full)
            bus.req_ready[r_grant] = 1'b1;
    end

    assign bus.fifo_we    = w_xfer;
    assign bus.fifo_wdata = w_lock ?
        bus.req_data[int'(r_grant)*WIDTH +: WIDTH] : '0;
    assign bus.grant_id   = r_grant;
    assign bus.busy       = (r_state == S_LOCK);

`ifdef FIFO_ARB_BURST_LOCK_EN
    localparam int BW = $clog2(MAX_BEATS + 1);

    logic [BW-1:0] r_beats;

    assign w_release = bus.req_last[r_grant] ||
                       (r_beats == BW'(MAX_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst)
            r_beats <= '0;
        else if (w_start)
            r_beats <= '0;
        else if (w_xfer)
            r_beats <= r_beats + 1'b1;
    end
`else
    logic w_unused;

    assign w_release = 1'b1;
    assign w_unused  = ^{bus.req_last, 32'(MAX_BEATS)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_LOCK;
                        r_grant <= w_win;
                    end
                end
                S_LOCK: begin
                    if (w_xfer && w_release) begin
                        r_state <= S_IDLE;
                        r_ptr   <= w_next_ptr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
